// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt sequencer: FSM states, cause codes,
// and cause classification functions.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_PROT  = 3'd1;
  localparam logic [2:0] CAUSE_PAGE  = 3'd2;
  localparam logic [2:0] CAUSE_UART  = 3'd3;
  localparam logic [2:0] CAUSE_TIMER = 3'd4;

  // Faults bypass the enable and boundary gating.
  function automatic logic is_fault(input logic [2:0] c);
    return (c == CAUSE_PROT) || (c == CAUSE_PAGE);
  endfunction

  function automatic logic is_maskable(input logic [2:0] c);
    return (c == CAUSE_UART) || (c == CAUSE_TIMER);
  endfunction

endpackage

// File: rtl/irq_cause_stack.sv
// One-deep save register holding the interrupted maskable cause while a fault
// handler runs. Only present in builds with IRQ_NEST_EN defined.
module irq_cause_stack
  import irq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [2:0] i_data,
  output logic       o_full,
  output logic [2:0] o_data
);

  logic       r_full;
  logic [2:0] r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= CAUSE_NONE;
    end else if (i_push) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/irq_sequencer.sv
// Registered interrupt sequencer: gates and latches the encoder cause, runs the
// CPU request/ack handshake and tracks service. IRQ_NEST_EN enables fault nesting.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int               VEC_W     = 16,
  parameter logic [VEC_W-1:0] VEC_BASE  = VEC_W'(16'h0010),
  parameter int               VEC_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             intr,
  input  logic [2:0]       irq_nr,
  input  logic             ie,
  input  logic             boundary,
  input  logic             irq_ack,
  input  logic             reti,
  output logic             cpu_irq,
  output logic [2:0]       cause,
  output logic [VEC_W-1:0] vector,
  output logic             in_service,
  output logic             double_fault
);

  irq_state_t r_state;
  irq_state_t w_state_next;
  logic [2:0] r_cause;
  logic [2:0] w_cause_next;
  logic       r_double_fault;
  logic       w_df_next;

  logic w_fault_take;
  logic w_take;

  assign w_fault_take = intr && is_fault(irq_nr);
  assign w_take       = w_fault_take || (intr && is_maskable(irq_nr) && ie && boundary);

`ifdef IRQ_NEST_EN
  logic       w_push;
  logic       w_pop;
  logic       w_stack_full;
  logic [2:0] w_saved_cause;

  irq_cause_stack u_stack (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (r_cause),
    .o_full (w_stack_full),
    .o_data (w_saved_cause)
  );
`endif

  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    w_df_next    = r_double_fault;
`ifdef IRQ_NEST_EN
    w_push = 1'b0;
    w_pop  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state_next = REQ;
          w_cause_next = irq_nr;
        end
      end
      REQ: begin
        if (irq_ack) w_state_next = SERVICE;
      end
      SERVICE: begin
        // reti has priority; a still-active source is re-sampled from IDLE.
        if (reti) begin
`ifdef IRQ_NEST_EN
          if (w_stack_full) begin
            w_pop        = 1'b1;
            w_cause_next = w_saved_cause;
          end else begin
            w_state_next = IDLE;
          end
`else
          w_state_next = IDLE;
`endif
        end else if (w_fault_take) begin
`ifdef IRQ_NEST_EN
          if (is_maskable(r_cause) && !w_stack_full) begin
            w_push       = 1'b1;
            w_cause_next = irq_nr;
            w_state_next = REQ;
          end else begin
            w_df_next = 1'b1;
          end
`else
          w_df_next = 1'b1;
`endif
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cause        <= CAUSE_NONE;
      r_double_fault <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cause        <= w_cause_next;
      r_double_fault <= w_df_next;
    end
  end

  assign cpu_irq      = (r_state == REQ);
  assign in_service   = (r_state == SERVICE);
  assign cause        = r_cause;
  assign vector       = VEC_BASE + (VEC_W'(r_cause) << VEC_SHIFT);
  assign double_fault = r_double_fault;

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Registered interrupt sequencer directly downstream of the combinational priority encoder. It samples the encoder's `intr`/`irq_nr` pair, applies global enable and instruction-boundary gating, and latches a stable cause. It then drives a request/acknowledge handshake to the CPU and tracks the in-service period until return-from-interrupt. Faults (causes 1, 2) are non-maskable, and a fault arriving while a handler is already running is reported as a double fault.

## Interface
Parameters:
- `VEC_W`, 16, width of the vector address output
- `VEC_BASE`, 16'h0010, vector address for cause 0
- `VEC_SHIFT`, 2, log2 of the spacing between vectors

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `intr`  in  1  encoder: some source active
- `irq_nr`  in  3  encoder: cause (1 prot, 2 page, 3 uart, 4 timer)
- `ie`  in  1  CPU global interrupt enable; gates causes 3–4 only
- `boundary`  in  1  CPU is at an instruction boundary; gates causes 3–4 only
- `irq_ack`  in  1  CPU has taken the vector (single-cycle pulse)
- `reti`  in  1  CPU executes return-from-interrupt (single-cycle pulse)
- `cpu_irq`  out  1  request to CPU
- `cause`  out  3  latched cause of the current request or service
- `vector`  out  VEC_W  handler address, computed as `VEC_BASE + (cause << VEC_SHIFT)`, modulo 2^VEC_W
- `in_service`  out  1  handler running
- `double_fault`  out  1  sticky error flag; cleared only by reset

## Operation
- State machine has three states: IDLE, REQ, SERVICE.
- Acceptance condition ("take"): `intr && (irq_nr ∈ {1,2} || (ie && boundary))`.
  - Causes 0 and 5–7 are never taken.
- **IDLE**
  - On take: latch `cause <= irq_nr` and go to REQ.
  - `irq_ack` and `reti` are ignored.
- **REQ**
  - `cpu_irq = 1`; `cause` is frozen.
  - `irq_ack` moves the block to SERVICE.
  - `intr` changes are ignored; a higher-priority fault does not replace the latched cause.
- **SERVICE**
  - `in_service = 1`.
  - `reti` returns to IDLE.
  - A fault take while in SERVICE follows the Configuration rules.
  - Maskable takes are ignored.
- **Simultaneous events**
  - `reti` together with `intr` in SERVICE: `reti` wins; `intr` is re-sampled from IDLE on the next cycle.
  - `irq_ack` together with a fault in REQ: `irq_ack` wins.
- Level sources that the handler has not cleared are re-taken starting the cycle after `reti`. Clearing the source is software's responsibility.
- Reset mid-operation: all state is discarded immediately and the block returns to IDLE.

## Timing
- Reset values:
  - `cpu_irq = 0`, `cause = 0`, `vector = VEC_BASE`, `in_service = 0`, `double_fault = 0`
  - state = IDLE; saved-cause register empty (when configured in)
- All outputs are registered or derived only from registers; none depends combinationally on inputs.
- Take sampled at edge N: `cpu_irq` and the new `cause`/`vector` are visible after edge N (one-cycle latency).
- `irq_ack` sampled at edge M: `cpu_irq` is 0 and `in_service` is 1 after edge M.
- `reti` sampled at edge K: `in_service` is 0 after edge K, unless a saved cause is restored.
- Minimum turnaround for back-to-back interrupts is 3 cycles: IDLE→REQ, one cycle of `cpu_irq`, then `irq_ack`.

## Configuration
- Macro: `IRQ_NEST_EN`.
- **Defined**
  - A fault take in SERVICE, while `cause` ∈ {3,4} and the save register is empty:
    - push `cause` into the one-deep save register;
    - latch the fault cause and go to REQ (`in_service` falls to 0).
  - `reti` with the save register full: pop, restore `cause`, return to SERVICE; `in_service` stays 1 across the edge.
  - A fault take in SERVICE while `cause` ∈ {1,2}, or while the save register is full: `double_fault <= 1` and state is unchanged.
- **Undefined**
  - Any fault take in SERVICE sets `double_fault <= 1` and state is unchanged.
  - The save register is absent.

## Structure
- Shared package `irq_pkg` holds:
  - state enum `irq_state_t` (IDLE, REQ, SERVICE)
  - cause constants `CAUSE_NONE`, `CAUSE_PROT`, `CAUSE_PAGE`, `CAUSE_UART`, `CAUSE_TIMER`
  - function `is_fault(cause)`
- Natural sub-module: `irq_cause_stack`, the one-deep save register with push, pop and full signals. It is instantiated only under `IRQ_NEST_EN`.

## Test plan
- **Reset:** assert `reset` mid-REQ with `cause=3` → all outputs return to their reset values immediately, and `vector` = 16'h0010.
- **Maskable take:** `ie=1`, `boundary=1`, `intr=1`, `irq_nr=4` → next cycle `cpu_irq=1`, `cause=4`, `vector=16'h0020`; then `irq_ack` → `cpu_irq=0`, `in_service=1`; then `reti` → `in_service=0`.
- **Masking:**
  - `ie=0`, `irq_nr=3` held for 10 cycles → `cpu_irq` stays 0.
  - `ie=0`, `irq_nr=1` → `cpu_irq=1`, `cause=1`.
- **Priority freeze:** in REQ with `cause=4`, raise `irq_nr=1` → `cause` stays 4 until `irq_ack`; at `reti`, with `irq_nr=1` still asserted, the block re-requests with `cause=1`.
- **Nesting** (`IRQ_NEST_EN`): page fault (`irq_nr=2`) during SERVICE of `cause=3` → REQ with `cause=2`; after `irq_ack`, `reti` → SERVICE with `cause=3`.
- **Double fault:** a second fault inside the nested fault handler → `double_fault=1`, and it persists after `reti`. Without the macro, the first fault in SERVICE sets `double_fault=1`.
